// File: rtl/spart_pkg.sv
// Shared definitions for the SPART echo driver: bus address map, FSM states, baud divisor table.
// Pure declarations; no state and no timing of its own.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    POLL,
    RX,
    TX,
    SETTLE
  } state_t;

  // 16-bit SPART divisor for each baud select code
  function automatic logic [15:0] baud_divisor(input logic [1:0] sel);
    logic [15:0] div;
    case (sel)
      2'b00:   div = 16'h028A;
      2'b01:   div = 16'h0145;
      2'b10:   div = 16'h00A2;
      default: div = 16'h0050;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/spart_driver_if.sv
// Control/status bundle between the echo driver and the SPART side; the data bus stays a plain inout net.
// Combinational wiring only.
interface spart_driver_if #(
  parameter int FIFO_DEPTH = 4
) ();

  logic [1:0]                    br_cfg;
  logic                          iocs;
  logic                          iorw;
  logic [1:0]                    ioaddr;
  logic                          cfg_done;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          rda_s;
  logic                          tbr_s;

  modport master (
    input  br_cfg,
    output iocs,
    output iorw,
    output ioaddr,
    output cfg_done,
    output fifo_count,
    output rda_s,
    output tbr_s
  );

  modport slave (
    output br_cfg,
    input  iocs,
    input  iorw,
    input  ioaddr,
    input  cfg_done,
    input  fifo_count,
    input  rda_s,
    input  tbr_s
  );

endinterface

// File: rtl/spart_echo_fifo.sv
// Byte FIFO holding received bytes until the SPART can accept them; push/pop take effect at the clock edge.
// Push while full and pop while empty are ignored, so the caller's full/empty checks are the backpressure.
module spart_echo_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Storage is not reset: occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spart_driver.sv
// Programs the SPART baud divisor, then polls status and echoes every received byte back out in order.
// One bus access per cycle with a SETTLE gap after each data access; a full buffer leaves rx data pending in the SPART.
module spart_driver
  import spart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  spart_driver_if.master  bus,
  inout  wire  [7:0]      databus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        r_state;
  state_t        w_nxt;
  logic [1:0]    r_br_cfg;
  logic [1:0]    r_cfg_cur;
  logic          r_cfg_done;
  logic          r_rda_s;
  logic          r_tbr_s;

  logic          w_iocs;
  logic          w_iorw;
  logic [1:0]    w_addr;
  logic [7:0]    w_wdat;
  logic          w_push;
  logic          w_pop;
  logic          w_cfg_chg;
  logic [15:0]   w_div;
  logic          w_cs_o;
  logic          w_rw_o;

  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;

  spart_echo_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (databus),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // CFG_LO takes the live select so the first access after reset uses the current br_cfg;
  // CFG_HI reuses the select latched during CFG_LO so both bytes always match.
  assign w_div     = baud_divisor((r_state == CFG_LO) ? bus.br_cfg : r_cfg_cur);
  assign w_cfg_chg = (r_br_cfg != r_cfg_cur);

  always_comb begin
    w_nxt  = r_state;
    w_iocs = 1'b0;
    w_iorw = 1'b1;
    w_addr = ADDR_DATA;
    w_wdat = 8'h00;
    w_push = 1'b0;
    w_pop  = 1'b0;
    case (r_state)
      CFG_LO: begin
        w_iocs = 1'b1;
        w_iorw = 1'b0;
        w_addr = ADDR_DIV_LO;
        w_wdat = w_div[7:0];
        w_nxt  = CFG_HI;
      end
      CFG_HI: begin
        w_iocs = 1'b1;
        w_iorw = 1'b0;
        w_addr = ADDR_DIV_HI;
        w_wdat = w_div[15:8];
        w_nxt  = POLL;
      end
      POLL: begin
        w_iocs = 1'b1;
        w_addr = ADDR_STATUS;
        if (w_cfg_chg) begin
          w_nxt = CFG_LO;
        end else if (databus[0] && !w_full) begin
          w_nxt = RX;
        end else if (databus[1] && !w_empty) begin
          w_nxt = TX;
        end else begin
          w_nxt = POLL;
        end
      end
      RX: begin
        w_iocs = 1'b1;
        w_push = 1'b1;
        w_nxt  = SETTLE;
      end
      TX: begin
        w_iocs = 1'b1;
        w_iorw = 1'b0;
        w_wdat = w_head;
        w_pop  = 1'b1;
        w_nxt  = SETTLE;
      end
      SETTLE: begin
        w_nxt = w_cfg_chg ? CFG_LO : POLL;
      end
      default: begin
        w_nxt = CFG_LO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CFG_LO;
      r_br_cfg   <= 2'b00;
      r_cfg_cur  <= 2'b00;
      r_cfg_done <= 1'b0;
      r_rda_s    <= 1'b0;
      r_tbr_s    <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_br_cfg <= bus.br_cfg;
      if (r_state == CFG_LO) begin
        r_cfg_cur <= bus.br_cfg;
      end
      if (r_state == CFG_HI) begin
        r_cfg_done <= 1'b1;
      end else if ((r_state == POLL || r_state == SETTLE) && w_cfg_chg) begin
        r_cfg_done <= 1'b0;
      end
      if (r_state == POLL) begin
        r_rda_s <= databus[0];
        r_tbr_s <= databus[1];
      end
    end
  end

  // Reset idles the bus immediately even though the state register already holds CFG_LO.
  assign w_cs_o = rst_n & w_iocs;
  assign w_rw_o = ~rst_n | w_iorw;

  assign bus.iocs       = w_cs_o;
  assign bus.iorw       = w_rw_o;
  assign bus.ioaddr     = rst_n ? w_addr : ADDR_DATA;
  assign bus.cfg_done   = r_cfg_done;
  assign bus.fifo_count = w_count;
  assign bus.rda_s      = r_rda_s;
  assign bus.tbr_s      = r_tbr_s;

  assign databus = (w_cs_o && !w_rw_o) ? w_wdat : 8'hzz;

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver with a small SPART model answering status/data reads and logging writes.
module tb_spart_driver;
  import spart_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wire [7:0] databus;
  spart_driver_if #(.FIFO_DEPTH(DEPTH)) bus ();

  spart_driver #(.FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .databus (databus)
  );

  // SPART model: queue of bytes waiting to be read, transmit log of bytes written
  logic       m_tbr = 1'b0;
  logic [7:0] rx_mem [32];
  int         rx_wr = 0;
  int         rx_rd = 0;
  logic [7:0] tx_mem [32];
  int         tx_n = 0;
  logic       m_rda;
  logic [7:0] m_rx;
  logic [7:0] tb_dat;
  logic       tb_drv;

  assign m_rda   = (rx_wr != rx_rd);
  assign m_rx    = rx_mem[rx_rd[4:0]];
  assign tb_drv  = bus.iocs && bus.iorw;
  assign tb_dat  = (bus.ioaddr == ADDR_STATUS) ? {6'b0, m_tbr, m_rda} : m_rx;
  assign databus = tb_drv ? tb_dat : 8'hzz;

  always @(posedge clk) begin
    if (bus.iocs && bus.iorw && bus.ioaddr == ADDR_DATA && m_rda) begin
      rx_rd <= rx_rd + 1;
    end
    if (bus.iocs && !bus.iorw && bus.ioaddr == ADDR_DATA) begin
      tx_mem[tx_n[4:0]] <= databus;
      tx_n <= tx_n + 1;
    end
  end

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;
  int tx_base;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {iocs, iorw, ioaddr}
  task automatic chk_bus(input string tag, input logic [3:0] exp);
    chk(tag, 16'({bus.iocs, bus.iorw, bus.ioaddr}), 16'(exp));
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_mem[rx_wr[4:0]] = b;
    rx_wr++;
  endtask

  task automatic wait_fill(input int cnt, input int pend, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = (int'(bus.fifo_count) == cnt) && ((rx_wr - rx_rd) == pend);
    end
    chk(tag, 16'(ok), 16'd1);
  endtask

  task automatic wait_tx(input int n, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = (tx_n == n);
    end
    chk(tag, 16'(ok), 16'd1);
  endtask

  initial begin
    bus.br_cfg = 2'b01;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_bus("rst_bus", 4'b0100);
    chk("rst_cfg_done", 16'(bus.cfg_done), 16'd0);
    chk("rst_count", 16'(bus.fifo_count), 16'd0);
    chk("rst_flags", 16'({bus.rda_s, bus.tbr_s}), 16'd0);

    // configuration at 9600
    rst_n = 1'b1;
    #1;
    chk_bus("cfg_lo_bus", 4'b1010);
    chk("cfg_lo_dat", 16'(databus), 16'h45);
    @(negedge clk);
    chk_bus("cfg_hi_bus", 4'b1011);
    chk("cfg_hi_dat", 16'(databus), 16'h01);
    chk("cfg_hi_done", 16'(bus.cfg_done), 16'd0);
    @(negedge clk);
    chk_bus("poll_bus", 4'b1101);
    chk("cfg_done", 16'(bus.cfg_done), 16'd1);

    // single byte echo
    rx_push(8'h5A);
    m_tbr = 1'b1;
    @(negedge clk);
    chk_bus("rx_bus", 4'b1100);
    chk("rx_dat", 16'(databus), 16'h5A);
    chk("rx_count", 16'(bus.fifo_count), 16'd0);
    @(negedge clk);
    chk_bus("settle_bus", 4'b0100);
    chk("settle_count", 16'(bus.fifo_count), 16'd1);
    chk("poll_flags_rx", 16'({bus.tbr_s, bus.rda_s}), 16'b11);
    @(negedge clk);
    chk_bus("poll2_bus", 4'b1101);
    @(negedge clk);
    chk_bus("tx_bus", 4'b1000);
    chk("tx_dat", 16'(databus), 16'h5A);
    chk("tx_count", 16'(bus.fifo_count), 16'd1);
    chk("poll_flags_tx", 16'({bus.tbr_s, bus.rda_s}), 16'b10);
    @(negedge clk);
    chk_bus("settle2_bus", 4'b0100);
    chk("tx_done_count", 16'(bus.fifo_count), 16'd0);
    chk("tx_log0", 16'(tx_mem[0]), 16'h5A);

    // fill past depth with tbr low
    m_tbr = 1'b0;
    for (int b = 8'h11; b <= 8'h15; b++) rx_push(8'(b));
    wait_fill(4, 1, "fill_full");
    repeat (10) @(negedge clk);
    chk("full_hold_count", 16'(bus.fifo_count), 16'd4);
    chk("full_pending", 16'(rx_wr - rx_rd), 16'd1);
    chk_bus("full_poll_bus", 4'b1101);

    // full buffer: TX first, then RX wins over TX with both qualifying
    tx_base = tx_n;
    m_tbr = 1'b1;
    @(negedge clk);
    chk_bus("full_tx_bus", 4'b1000);
    chk("full_tx_dat", 16'(databus), 16'h11);
    @(negedge clk);
    chk("after_tx_count", 16'(bus.fifo_count), 16'd3);
    @(negedge clk);
    chk_bus("prio_poll_bus", 4'b1101);
    @(negedge clk);
    chk_bus("prio_rx_bus", 4'b1100);
    chk("prio_rx_dat", 16'(databus), 16'h15);
    @(negedge clk);
    chk("prio_count", 16'(bus.fifo_count), 16'd4);
    wait_tx(tx_base + 5, "drain5");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("order%0d", k), 16'(tx_mem[5'(tx_base + k)]), 16'(8'h11 + k));
    end
    chk("drain_count", 16'(bus.fifo_count), 16'd0);

    // baud change with bytes buffered
    m_tbr = 1'b0;
    rx_push(8'h21);
    rx_push(8'h22);
    wait_fill(2, 0, "fill2");
    @(negedge clk);
    chk_bus("idle_poll_bus", 4'b1101);
    bus.br_cfg = 2'b11;
    @(negedge clk);
    chk_bus("chg_poll_bus", 4'b1101);
    chk("chg_poll_done", 16'(bus.cfg_done), 16'd1);
    @(negedge clk);
    chk_bus("recfg_lo_bus", 4'b1010);
    chk("recfg_lo_dat", 16'(databus), 16'h50);
    chk("recfg_done_clr", 16'(bus.cfg_done), 16'd0);
    @(negedge clk);
    chk_bus("recfg_hi_bus", 4'b1011);
    chk("recfg_hi_dat", 16'(databus), 16'h00);
    @(negedge clk);
    chk("recfg_done", 16'(bus.cfg_done), 16'd1);
    chk("recfg_count", 16'(bus.fifo_count), 16'd2);
    tx_base = tx_n;
    m_tbr = 1'b1;
    wait_tx(tx_base + 2, "drain2");
    chk("kept0", 16'(tx_mem[5'(tx_base)]), 16'h21);
    chk("kept1", 16'(tx_mem[5'(tx_base + 1)]), 16'h22);

    // reset mid-operation with three bytes buffered
    m_tbr = 1'b0;
    rx_push(8'h31);
    rx_push(8'h32);
    rx_push(8'h33);
    wait_fill(3, 0, "fill3");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_bus("mid_rst_bus", 4'b0100);
    chk("mid_rst_count", 16'(bus.fifo_count), 16'd0);
    chk("mid_rst_done", 16'(bus.cfg_done), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_bus("rel_lo_bus", 4'b1010);
    chk("rel_lo_dat", 16'(databus), 16'h50);
    @(negedge clk);
    chk_bus("rel_hi_bus", 4'b1011);
    @(negedge clk);
    chk("rel_done", 16'(bus.cfg_done), 16'd1);
    tx_base = tx_n;
    m_tbr = 1'b1;
    repeat (12) @(negedge clk);
    chk("discarded_tx", 16'(tx_n - tx_base), 16'd0);
    chk("discarded_count", 16'(bus.fifo_count), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/spart_driver.md
SPART_DRIVER -- requirements
Module: spart_driver

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, echo-buffer entries (power of two, >=2).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 br_cfg  input  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400.
REQ-005 iocs  output  1  SPART chip select, high for exactly one cycle per bus access.
REQ-006 iorw  output  1  1=read from SPART, 0=write to SPART.
REQ-007 ioaddr  output  2  00=data (tx write / rx read), 01=status read {6'b0,tbr,rda}, 10=divisor low, 11=divisor high.
REQ-008 databus  inout  8  shared data bus; driver drives only when iocs=1 and iorw=0, else high-Z.
REQ-009 cfg_done  output  1  high once both divisor bytes are written for the current br_cfg.
REQ-010 fifo_count  output  clog2(FIFO_DEPTH)+1  current echo-buffer occupancy.

Function
REQ-011 Divisor values SHALL be 4800=0x028A, 9600=0x0145, 19200=0x00A2, 38400=0x0050.
REQ-012 FSM states SHALL be CFG_LO, CFG_HI, POLL, RX, TX, SETTLE.
REQ-013 CFG_LO: iocs=1, iorw=0, ioaddr=10, databus=divisor[7:0]; next CFG_HI.
REQ-014 CFG_HI: iocs=1, iorw=0, ioaddr=11, databus=divisor[15:8]; cfg_done set at end of cycle; next POLL.
REQ-015 POLL: iocs=1, iorw=1, ioaddr=01; databus sampled same cycle into rda_s=databus[0], tbr_s=databus[1].
REQ-016 From POLL: rda_s=1 and buffer not full -> RX; else tbr_s=1 and buffer not empty -> TX; else POLL.
REQ-017 RX has priority over TX when both qualify.
REQ-018 RX: iocs=1, iorw=1, ioaddr=00; databus byte pushed to buffer at end of cycle; next SETTLE.
REQ-019 TX: iocs=1, iorw=0, ioaddr=00, databus=buffer head; head popped at end of cycle; next SETTLE.
REQ-020 SETTLE: iocs=0 for one cycle so SPART flags update; next POLL.
REQ-021 rda_s=1 with buffer full SHALL NOT read the SPART; byte stays pending in SPART.
REQ-022 Buffer SHALL be FIFO order; pointers wrap modulo FIFO_DEPTH; push and pop never in same cycle.
REQ-023 br_cfg sampled into a register each cycle; a change detected in POLL or SETTLE SHALL clear cfg_done and go to CFG_LO next cycle; RX/TX in progress complete first; buffer contents retained.
REQ-024 When iocs=0, iorw=1 and ioaddr=00 (bus idle, driver not driving).
REQ-025 Latency: received byte SHALL appear on the bus in TX no earlier than 4 cycles after the POLL seeing rda (POLL, RX, SETTLE, POLL, TX).

Reset
REQ-026 On rst_n=0 asynchronously: state=CFG_LO, iocs=0, iorw=1, ioaddr=00, databus high-Z, cfg_done=0, fifo_count=0, pointers=0, rda_s=tbr_s=0, br_cfg register=00.
REQ-027 Reset asserted mid-operation SHALL discard buffer contents; first cycle after release performs CFG_LO with current br_cfg.

Structure
REQ-028 spart_pkg SHALL hold ioaddr constants, state enum, and divisor table function.
REQ-029 Echo buffer SHALL be sub-module spart_echo_fifo (push, pop, din, dout, full, empty, count).
REQ-030 Top-level tristate SHALL be a single continuous assignment on databus.

Verification
REQ-031 Reset release, br_cfg=01 -> CFG_LO writes 0x45 @ addr 10, next cycle 0x01 @ addr 11, cfg_done=1.
REQ-032 Status model rda=1 with data 0x5A, tbr=1 -> RX reads 0x5A, SETTLE, later TX writes 0x5A @ addr 00, fifo_count 1->0.
REQ-033 tbr=0, five bytes 0x11..0x15 arrive (depth 4) -> 0x11..0x14 buffered, fifo_count=4, no RX for 0x15 until tbr=1; output order 0x11,0x12,0x13,0x14,0x15.
REQ-034 rda=1 and tbr=1 with buffer non-empty in same POLL -> RX taken first.
REQ-035 br_cfg changes 01->11 during idle POLL -> cfg_done=0, writes 0x50 then 0x00, buffered bytes still transmitted after.
REQ-036 rst_n pulsed low while fifo_count=3 -> outputs at reset values immediately, fifo_count=0, reconfiguration follows release.
